master_slave_checker: RTL and testbench

//  Observer at the receiving end of the master-slave D flip-flop interface.

---
 rtl/master_slave_checker.sv | 94 +++++++++
 tb/tb_master_slave_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/master_slave_checker.sv
// Observer for a flip-flop under test: one-cycle reference model on D,
// compares returned Q each cycle and reports results after NUM_CHECKS compares.
module master_slave_checker #(
  parameter int unsigned NUM_CHECKS = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             En,
  input  logic             D,
  input  logic             Q,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] ErrCnt,
  output logic [CNT_W-1:0] FirstErr
);

  localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] chk, chk_nxt;
  logic [CNT_W-1:0] err_nxt, first_nxt;
  logic             exp_q, exp_nxt;

  // State, model and result registers; flags are decoded from next values
  // so they line up with the registered state.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state    <= IDLE;
      chk      <= '0;
      exp_q    <= 1'b0;
      ErrCnt   <= '0;
      FirstErr <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
    end else begin
      state    <= state_nxt;
      chk      <= chk_nxt;
      exp_q    <= exp_nxt;
      ErrCnt   <= err_nxt;
      FirstErr <= first_nxt;
      Busy     <= (state_nxt == CHECK);
      Done     <= (state_nxt == DONE);
      Pass     <= (state_nxt == DONE) && (err_nxt == '0);
    end
  end

  // Next-state and result update.
  always_comb begin
    state_nxt = state;
    chk_nxt   = chk;
    exp_nxt   = exp_q;
    err_nxt   = ErrCnt;
    first_nxt = FirstErr;
    case (state)
      IDLE: begin
        if (En) begin
          err_nxt   = '0;
          first_nxt = '0;
          chk_nxt   = '0;
          exp_nxt   = D;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (En) begin
          exp_nxt = D;
          chk_nxt = chk + CNT_W'(1);
          if (Q != exp_q) begin
            if (ErrCnt != ERR_MAX) err_nxt = ErrCnt + CNT_W'(1);
            if (ErrCnt == '0)      first_nxt = chk;
          end
          if (chk == LAST_CHK) state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (!En) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_master_slave_checker.sv
// Directed bench for master_slave_checker: default build plus a 3-bit/7-check
// build and a single-check build, driven from an ideal or faulted flip-flop.
module tb_master_slave_checker;

  logic       clk = 1'b0;
  logic       resetn, en, en2, d;
  logic       stuck, inv_now, dff_q;
  logic       q1, q2;
  logic       busy1, done1, pass1;
  logic [7:0] err1, first1;
  logic       busy2, done2, pass2;
  logic [2:0] err2, first2;
  logic       busy3, done3, pass3;
  logic [2:0] err3, first3;
  logic [16:0] pat;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Ideal flip-flop under test; fault injection happens on the returned Q.
  always_ff @(posedge clk) dff_q <= d;
  assign q1 = stuck ? 1'b0 : (dff_q ^ inv_now);
  assign q2 = ~dff_q;

  master_slave_checker u_dut1 (
    .Clk(clk), .Resetn(resetn), .En(en), .D(d), .Q(q1),
    .Busy(busy1), .Done(done1), .Pass(pass1), .ErrCnt(err1), .FirstErr(first1)
  );

  master_slave_checker #(.NUM_CHECKS(7), .CNT_W(3)) u_dut2 (
    .Clk(clk), .Resetn(resetn), .En(en2), .D(d), .Q(q2),
    .Busy(busy2), .Done(done2), .Pass(pass2), .ErrCnt(err2), .FirstErr(first2)
  );

  master_slave_checker #(.NUM_CHECKS(1), .CNT_W(3)) u_dut3 (
    .Clk(clk), .Resetn(resetn), .En(en2), .D(d), .Q(q2),
    .Busy(busy3), .Done(done3), .Pass(pass3), .ErrCnt(err3), .FirstErr(first3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges; inv_k selects the edge whose Q is inverted; alt gives D=1,0,1,...
  task automatic drive(input int n, input int inv_k, input logic alt);
    for (int k = 0; k < n; k++) begin
      d       = alt ? ~k[0] : pat[k % 17];
      inv_now = (k == inv_k);
      tick();
    end
    inv_now = 1'b0;
  endtask

  initial begin
    pat     = 17'b1_0011_1001_0110_1100;
    resetn  = 1'b0;
    en      = 1'b0;
    en2     = 1'b0;
    d       = 1'b0;
    stuck   = 1'b0;
    inv_now = 1'b0;
    tick();
    tick();
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_done",  32'(done1),  32'd0);
    check("rst_pass",  32'(pass1),  32'd0);
    check("rst_err",   32'(err1),   32'd0);
    check("rst_first", 32'(first1), 32'd0);
    resetn = 1'b1;
    tick();

    // T1: ideal flip-flop, 1 start edge + 16 compares
    en = 1'b1;
    drive(16, -1, 1'b0);
    check("t1_busy_15", 32'(busy1), 32'd1);
    check("t1_done_15", 32'(done1), 32'd0);
    drive(1, -1, 1'b0);
    check("t1_done", 32'(done1), 32'd1);
    check("t1_pass", 32'(pass1), 32'd1);
    check("t1_err",  32'(err1),  32'd0);
    check("t1_busy", 32'(busy1), 32'd0);
    tick();
    check("t1_done_hold", 32'(done1), 32'd1);
    en = 1'b0;
    tick();
    check("t1_idle_done", 32'(done1), 32'd0);
    check("t1_idle_pass", 32'(pass1), 32'd0);

    // T2: Q stuck at 0, D alternating from 1
    stuck = 1'b1;
    en    = 1'b1;
    drive(17, -1, 1'b1);
    check("t2_done",  32'(done1),  32'd1);
    check("t2_err",   32'(err1),   32'd8);
    check("t2_first", 32'(first1), 32'd0);
    check("t2_pass",  32'(pass1),  32'd0);
    en = 1'b0;
    tick();
    stuck = 1'b0;
    check("t2_idle_err", 32'(err1), 32'd8);

    // T3: single inverted Q at check index 5 (edge 6 of the run)
    en = 1'b1;
    drive(17, 6, 1'b0);
    check("t3_done",  32'(done1),  32'd1);
    check("t3_err",   32'(err1),   32'd1);
    check("t3_first", 32'(first1), 32'd5);
    check("t3_pass",  32'(pass1),  32'd0);
    en = 1'b0;
    tick();

    // T4: 3-bit counters, 7 checks, Q always inverted; plus NUM_CHECKS=1
    en2 = 1'b1;
    tick();
    check("n1_busy", 32'(busy3), 32'd1);
    tick();
    check("n1_done",  32'(done3),  32'd1);
    check("n1_err",   32'(err3),   32'd1);
    check("n1_first", 32'(first3), 32'd0);
    check("n1_pass",  32'(pass3),  32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t4_done_6", 32'(done2), 32'd0);
    check("t4_err_6",  32'(err2),  32'd6);
    tick();
    check("t4_done",  32'(done2),  32'd1);
    check("t4_err",   32'(err2),   32'd7);
    check("t4_first", 32'(first2), 32'd0);
    check("t4_pass",  32'(pass2),  32'd0);
    tick();
    check("t4_err_hold", 32'(err2), 32'd7);
    en2 = 1'b0;
    tick();

    // T5: abort after 4 compares with one error at index 1, then restart
    en = 1'b1;
    drive(5, 2, 1'b0);
    check("t5_busy",  32'(busy1),  32'd1);
    check("t5_err",   32'(err1),   32'd1);
    check("t5_first", 32'(first1), 32'd1);
    en = 1'b0;
    tick();
    check("t5_abort_busy",  32'(busy1),  32'd0);
    check("t5_abort_done",  32'(done1),  32'd0);
    check("t5_abort_err",   32'(err1),   32'd1);
    check("t5_abort_first", 32'(first1), 32'd1);
    en = 1'b1;
    tick();
    check("t5_restart_busy",  32'(busy1),  32'd1);
    check("t5_restart_err",   32'(err1),   32'd0);
    check("t5_restart_first", 32'(first1), 32'd0);
    drive(15, -1, 1'b0);
    check("t5_done_15", 32'(done1), 32'd0);
    drive(1, -1, 1'b0);
    check("t5_done", 32'(done1), 32'd1);
    check("t5_pass", 32'(pass1), 32'd1);

    // T6: reset pulse mid-run discards partial results
    en = 1'b0;
    tick();
    en = 1'b1;
    drive(5, 3, 1'b0);
    check("t6_pre_err",   32'(err1),   32'd1);
    check("t6_pre_first", 32'(first1), 32'd2);
    resetn = 1'b0;
    tick();
    check("t6_busy",  32'(busy1),  32'd0);
    check("t6_done",  32'(done1),  32'd0);
    check("t6_err",   32'(err1),   32'd0);
    check("t6_first", 32'(first1), 32'd0);
    resetn = 1'b1;
    tick();
    check("t6_start_busy", 32'(busy1), 32'd1);
    drive(16, -1, 1'b0);
    check("t6_done_final", 32'(done1), 32'd1);
    check("t6_pass_final", 32'(pass1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
